// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the iterative ALU.
// Holds the ALU operation codes, the control FSM state enum and the flag bit positions.
// Imported by alu_iter and alu_muldiv_iter.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ORR  = 3'b011,
    ALU_EOR  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_UDIV = 3'b110,
    ALU_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // True for the operations that run through the iterative datapath
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == ALU_MUL) || (op == ALU_UDIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shift-add multiplier / restoring divider, one bit per step.
// Latency: WIDTH steps after load; result is valid combinationally during the step where last=1.
// Backpressure: none; the owner asserts step every cycle while the op is in flight.
// Ports: clk, reset (sync, active-high); load captures op/a/b and sets counter to WIDTH-1;
//        step advances one iteration; result is the value after the current step; last flags counter==0.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  // opa: multiplicand (shifts left) or dividend/quotient (shifts left, quotient bits enter at LSB)
  // opb: multiplier (shifts right) or divisor (static)
  // acc: product accumulator or partial remainder
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             div_zero;

  logic [WIDTH-1:0] acc_mul;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    acc_mul  = opb[0] ? (acc + opa) : acc;
    rem_sh   = {acc, opa[WIDTH-1]};
    diff     = rem_sh - {1'b0, opb};
    // remainder < divisor, so the shifted remainder is below 2*divisor: bit WIDTH of the
    // difference is set exactly when the trial subtraction would go negative
    borrow   = diff[WIDTH];
    rem_next = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {opa[WIDTH-2:0], ~borrow};
    last     = (count == '0);
    if (is_div) begin
      // a zero divisor would naturally yield all ones; force 0 instead
      result = div_zero ? '0 : quo_next;
    end else begin
      result = acc_mul;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      opa      <= a;
      opb      <= b;
      acc      <= '0;
      count    <= CW'(WIDTH - 1);
      is_div   <= (op == ALU_UDIV);
      div_zero <= (b == '0);
    end else if (step) begin
      if (is_div) begin
        acc <= rem_next;
        opa <= quo_next;
      end else begin
        acc <= acc_mul;
        opa <= opa << 1;
        opb <= opb >> 1;
      end
      if (!last) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with start/done handshake and registered Result/ALUFlags.
// Latency: single-cycle ops done at t+1, MUL/UDIV done at t+WIDTH+1 after accept at edge t.
// Backpressure: busy high during MUL/UDIV; start while busy is dropped, never queued.
// Ports: clk, reset (sync, active-high), start, a, b, ALUControl in;
//        busy, done (1-cycle pulse), Result, ALUFlags {N,Z,C,V} out.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  state_e state;
  state_e state_nxt;

  logic             accept;
  logic             md_load;
  logic             md_step;
  logic             md_last;
  logic [WIDTH-1:0] md_result;

  logic             res_we;
  logic [WIDTH-1:0] res_nxt;
  logic [3:0]       flags_nxt;

  // Single-cycle datapath
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_result;
  logic             sc_c;
  logic             sc_v;

  always_comb begin
    is_sub    = (ALUControl == ALU_SUB);
    b_eff     = is_sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sc_result = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    case (ALUControl)
      ALU_ADD, ALU_SUB: begin
        sc_result = sum[WIDTH-1:0];
        sc_c      = sum[WIDTH];
        // overflow: operands of equal sign producing a result of the other sign
        sc_v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: sc_result = a & b;
      ALU_ORR: sc_result = a | b;
      ALU_EOR: sc_result = a ^ b;
      default: sc_result = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .op     (ALUControl),
    .a      (a),
    .b      (b),
    .step   (md_step),
    .result (md_result),
    .last   (md_last)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state, handshake outputs and result-register write control
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    md_load   = 1'b0;
    md_step   = 1'b0;
    res_we    = 1'b0;
    res_nxt   = Result;
    flags_nxt = ALUFlags;

    case (state)
      ST_IDLE: begin
        accept = start;
      end
      ST_ITER: begin
        busy    = 1'b1;
        md_step = 1'b1;
        if (md_last) begin
          res_we    = 1'b1;
          res_nxt   = md_result;
          flags_nxt = {md_result[WIDTH-1], (md_result == '0), 1'b0, 1'b0};
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
        accept    = start;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (accept) begin
      if (is_iter_op(ALUControl)) begin
        md_load   = 1'b1;
        state_nxt = ST_ITER;
      end else begin
        res_we    = 1'b1;
        res_nxt   = sc_result;
        flags_nxt = {sc_result[WIDTH-1], (sc_result == '0), sc_c, sc_v};
        state_nxt = ST_DONE;
      end
    end
  end

  // Result and flags only move on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      Result   <= '0;
      ALUFlags <= 4'b0000;
    end else if (res_we) begin
      Result   <= res_nxt;
      ALUFlags <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed plus randomized checks of alu_iter at WIDTH=32.
// Expected values come from an arithmetic reference model of the operation set.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    ALUControl;
  logic          busy;
  logic          done;
  logic [W-1:0]  Result;
  logic [3:0]    ALUFlags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .ALUFlags   (ALUFlags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {N,Z,C,V, result}
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        c;
    logic        v;
    longint      s;
    logic [63:0] ux;
    logic [63:0] uy;
    c  = 1'b0;
    v  = 1'b0;
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      3'd0: begin
        r = x + y;
        c = (ux + uy) > 64'h0000_0000_FFFF_FFFF;
        s = longint'($signed(x)) + longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
        s = longint'($signed(x)) - longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x * y;
      3'd6: r = (y == 0) ? 32'd0 : x / y;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Issue one op, wait for done, check latency, busy profile, result, flags and hold.
  // inject>0 pulses an ADD start during that cycle of the in-flight op.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int inject,
                        output logic [31:0] res, output logic [3:0] fl);
    logic [35:0] exp;
    int          n;
    int          lat;
    int          busy_bad;
    logic        iter;
    exp      = model(op, x, y);
    iter     = (op == 3'd5) || (op == 3'd6);
    busy_bad = 0;
    lat      = 0;
    @(negedge clk);
    start = 1'b1; ALUControl = op; a = x; b = y;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== iter) busy_bad++;
      start = (n == inject);
      if (n == inject) begin
        ALUControl = 3'd0; a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), iter ? 64'd33 : 64'd1);
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_result"}, {32'd0, Result}, {32'd0, exp[31:0]});
    check({tag, "_flags"}, {60'd0, ALUFlags}, {60'd0, exp[35:32]});
    res = Result;
    fl  = ALUFlags;
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_hold"}, {28'd0, ALUFlags, Result}, {28'd0, exp});
  endtask

  initial begin : stim
    logic [31:0] r;
    logic [3:0]  f;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    int          ndone;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; ALUControl = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, Result}, 64'd0);
    check("rst_flags", {60'd0, ALUFlags}, 64'd0);
    reset = 1'b0;

    // Directed cases with hand-derived constants alongside the model
    run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, r, f);
    check("add_ovf_const", {28'd0, f, r}, {28'd0, 4'b1001, 32'h8000_0000});
    run_op("sub_eq", 3'd1, 32'd5, 32'd5, 0, r, f);
    check("sub_eq_const", {28'd0, f, r}, {28'd0, 4'b0110, 32'd0});
    run_op("sub_neg", 3'd1, 32'd3, 32'd5, 0, r, f);
    check("sub_neg_const", {28'd0, f, r}, {28'd0, 4'b1000, 32'hFFFF_FFFE});
    run_op("mul", 3'd5, 32'h0001_0003, 32'd5, 10, r, f);
    check("mul_const", {28'd0, f, r}, {28'd0, 4'b0000, 32'h0005_000F});
    run_op("udiv", 3'd6, 32'd100, 32'd7, 0, r, f);
    check("udiv_const", {32'd0, r}, 64'd14);
    run_op("udiv0", 3'd6, 32'hFFFF_FFFF, 32'd0, 0, r, f);
    check("udiv0_const", {28'd0, f, r}, {28'd0, 4'b0100, 32'd0});

    // Reset during the 10th ITER cycle discards the op
    @(negedge clk);
    start = 1'b1; ALUControl = 3'd5; a = 32'h1234_5678; b = 32'h0000_0777;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_state", {28'd0, ALUFlags, Result}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run_op("add_after_rst", 3'd0, 32'd2, 32'd2, 0, r, f);
    check("add_after_rst_const", {28'd0, f, r}, {28'd0, 4'b0000, 32'd4});

    // Back-to-back EOR with start held through DONE
    @(negedge clk);
    start = 1'b1; ALUControl = 3'd4; a = 32'hF0F0_F0F0; b = 32'hFFFF_FFFF;
    @(negedge clk);
    check("b2b_done1", {63'd0, done}, 64'd1);
    check("b2b_res1", {28'd0, ALUFlags, Result}, {28'd0, 4'b0000, 32'h0F0F_0F0F});
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done2", {63'd0, done}, 64'd1);
    check("b2b_res2", {28'd0, ALUFlags, Result}, {28'd0, 4'b0100, 32'd0});
    @(negedge clk);
    check("b2b_idle", {63'd0, done}, 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      if (op == 3'd6) begin
        y = ($urandom_range(0, 4) == 0) ? 32'd0 : (y >> $urandom_range(0, 31));
      end
      if (i % 5 == 0) x = x >> $urandom_range(16, 31);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, x, y,
             (op >= 3'd5) ? int'($urandom_range(0, 31)) : 0, r, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised multi-cycle successor to the single-cycle datapath ALU. It adds EOR, iterative MUL and UDIV, a start/done handshake, and registered result and flags. It sits between the register-file read ports and the writeback/flag-update logic of the multi-cycle core. The control FSM stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand, result and internal datapath width; must be ≥ 4.

Ports:
- `clk`  in  1  single clock, all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  request; accepted only while `busy`=0.
- `a`  in  WIDTH  operand A, captured on accept.
- `b`  in  WIDTH  operand B, captured on accept.
- `ALUControl`  in  3  operation, captured on accept:
  - 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL (low WIDTH bits), 110 UDIV, 111 reserved.
- `busy`  out  1  high while an iterative op is in progress.
- `done`  out  1  one-cycle pulse; `Result`/`ALUFlags` are valid from this cycle on.
- `Result`  out  WIDTH  registered result, held until the next `done`.
- `ALUFlags`  out  4  registered {N,Z,C,V}, held until the next `done`.

## Operation
- FSM states: IDLE, ITER, DONE.
  - IDLE: `busy`=0, `done`=0.
  - ITER: `busy`=1.
  - DONE: `done`=1, `busy`=0; `start` is accepted in DONE, giving back-to-back issue.
- Accept with a single-cycle op (ADD/SUB/AND/ORR/EOR/111): compute, register `Result`/`ALUFlags`, go to DONE.
- Accept with MUL/UDIV: load operands and counter=WIDTH-1, go to ITER.
  - Each cycle performs one iteration and decrements the counter.
  - At counter=0 the final result is registered and the FSM goes to DONE.
- From DONE: go to IDLE, or re-accept if `start`=1.
- `start` while `busy`=1: ignored; no queueing, and the in-flight operands are unaffected.
- Arithmetic:
  - ADD/SUB: sum = a + (SUB ? ~b : b) + SUB, computed WIDTH+1 bits wide.
  - MUL: shift-add, one multiplier bit per cycle, product truncated to WIDTH.
  - UDIV: restoring division, one quotient bit per cycle; b=0 gives quotient 0.
  - 111: Result=0.
- Flags:
  - N = Result[WIDTH-1].
  - Z = (Result==0).
  - C = sum[WIDTH] for ADD/SUB (SUB: C=1 means no borrow); 0 otherwise.
  - V = signed overflow for ADD/SUB; 0 otherwise.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `Result`=0, `ALUFlags`=4'b0000, counter=0.
- Reset overrides everything, including mid-ITER; the op is discarded with no `done`.
- Single-cycle op accepted at edge t: `done` high in cycle t+1.
- MUL/UDIV accepted at edge t: `busy` high cycles t+1..t+WIDTH, `done` high in cycle t+WIDTH+1.
- Throughput:
  - one single-cycle op per 1 cycle when `start` is held;
  - one MUL/UDIV per WIDTH+1 cycles when reissued in DONE.
- `Result`/`ALUFlags` change only on the edge that raises `done`, or on reset.

## Structure
- Shared package `alu_pkg`: op encodings (`ALU_ADD`…`ALU_UDIV`), FSM state enum, flag bit indices (N=3, Z=2, C=1, V=0).
- Sub-module `alu_muldiv_iter`:
  - ports: clk, reset, load, op, a, b, step; outputs result, last.
  - holds the shift registers and counter.
- The top level keeps the FSM, the single-cycle ops and the flag logic.

## Test plan
All at WIDTH=32.
- ADD 0x7FFFFFFF + 0x00000001 -> Result 0x80000000, flags 1001, `done` at t+1, `busy` never high.
- SUB 5 - 5 -> Result 0, flags 0110. SUB 3 - 5 -> Result 0xFFFFFFFE, flags 1000.
- MUL 0x00010003 × 5 -> Result 0x0005000F, flags 0000.
  - `busy` t+1..t+32, `done` exactly at t+33.
  - ADD start pulsed at t+10 is ignored; Result is unchanged by it.
- UDIV 100 / 7 -> Result 14, `done` at t+33. UDIV 0xFFFFFFFF / 0 -> Result 0, flags 0100.
- Reset asserted in the 10th ITER cycle -> next cycle `busy`=0, `done`=0, Result 0, flags 0000, and no later `done`. A following ADD 2+2 -> Result 4, flags 0000.
- EOR 0xF0F0F0F0 ^ 0xFFFFFFFF -> 0x0F0F0F0F, flags 0000. With `start` held in DONE, the next EOR 0xFFFFFFFF ^ 0xFFFFFFFF -> 0, flags 0100, on consecutive `done` cycles.
